// File: rtl/epc_slave_regs_if.sv
// epc_slave_regs_if: EPC bus between the PS master and the PL register responder
// Ports: epc_cs_n/epc_addr/epc_be/epc_rnw/epc_rd_n/epc_wr_n/epc_data_i driven by master;
//        epc_data_o/epc_rdy driven by slave. Big-endian vectors, bit 0 is the MSB.
interface epc_slave_regs_if;
  logic        epc_cs_n;
  logic [0:31] epc_addr;
  logic [0:3]  epc_be;
  logic        epc_rnw;
  logic        epc_rd_n;
  logic        epc_wr_n;
  logic [0:31] epc_data_i;
  logic [0:31] epc_data_o;
  logic        epc_rdy;
  modport master (output epc_cs_n, epc_addr, epc_be, epc_rnw, epc_rd_n, epc_wr_n, epc_data_i,
                  input epc_data_o, epc_rdy);
  modport slave (input epc_cs_n, epc_addr, epc_be, epc_rnw, epc_rd_n, epc_wr_n, epc_data_i,
                 output epc_data_o, epc_rdy);
endinterface

// File: rtl/epc_slave_regs.sv
// epc_slave_regs: EPC bus responder decoding read/write cycles into RW control and RO status registers
// Ports: clk, rst_n (async, active low); bus (epc_slave_regs_if.slave);
//        ctl_o (NREG x 32 control regs, reg k at [32k+31:32k]); ctl_wr_o (per-reg write pulse);
//        stat_i (NSTAT x 32 status inputs). With EPC_SLAVE_IRQ_EN defined: evt_i[31:0] and irq_o,
//        plus a write-1-to-clear pending register at index NREG+NSTAT.
module epc_slave_regs #(
  parameter int NREG        = 4,
  parameter int NSTAT       = 4,
  parameter int IDX_W       = 4,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  epc_slave_regs_if.slave       bus,
  output logic [NREG*32-1:0]    ctl_o,
  output logic [NREG-1:0]       ctl_wr_o,
  input  logic [NSTAT*32-1:0]   stat_i
`ifdef EPC_SLAVE_IRQ_EN
  ,
  input  logic [31:0]           evt_i,
  output logic                  irq_o
`endif
);
  localparam int IDX_LO = 30 - IDX_W;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_HOLD} state_t;
  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [3:0]             be_q, be_d;
  logic                   rnw_q, rnw_d;
  logic [31:0]            wdat_q, wdat_d;
  logic                   rdy_q;
  logic [31:0]            rdat_q, rd_val, mask;
  logic [NREG-1:0][31:0]  ctl_q;
  logic [NREG-1:0]        ctl_wr_q;
  logic                   start, hold_done, ack, wr_go, unused_addr;
  assign start       = !bus.epc_cs_n && (!bus.epc_rd_n || !bus.epc_wr_n);
  assign hold_done   = bus.epc_cs_n || (bus.epc_rd_n && bus.epc_wr_n);
  assign ack         = state_q == S_ACK;
  assign wr_go       = ack && !rnw_q && |be_q;
  // be_q[3] holds epc_be[0], which enables the most significant byte
  assign mask        = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};
  assign unused_addr = ^{bus.epc_addr[0:IDX_LO-1], bus.epc_addr[30:31]};
  assign bus.epc_rdy    = rdy_q;
  assign bus.epc_data_o = rdat_q;
  assign ctl_o          = ctl_q;
  assign ctl_wr_o       = ctl_wr_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    be_d    = be_q;
    rnw_d   = rnw_q;
    wdat_d  = wdat_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = WAIT_STATES == 0 ? S_ACK : S_WAIT;
        cnt_d   = WAIT_STATES == 0 ? 4'd0 : 4'(WAIT_STATES - 1);
        idx_d   = bus.epc_addr[IDX_LO:29];
        be_d    = bus.epc_be;
        rnw_d   = (!bus.epc_rd_n && !bus.epc_wr_n) ? bus.epc_rnw : !bus.epc_rd_n;
        wdat_d  = bus.epc_data_i;
      end
      // losing chip select while waiting abandons the access without ack or commit
      S_WAIT: begin
        state_d = bus.epc_cs_n ? S_IDLE : cnt_q == 4'd0 ? S_ACK : S_WAIT;
        cnt_d   = (bus.epc_cs_n || cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
      end
      S_ACK:   state_d = S_HOLD;
      default: state_d = hold_done ? S_IDLE : S_HOLD;
    endcase
  end
`ifdef EPC_SLAVE_IRQ_EN
  logic [31:0] evt_q, pend_q, pend_clr;
  logic        irq_q;
  assign pend_clr = (wr_go && idx_q == IDX_W'(NREG + NSTAT)) ? wdat_q & mask : 32'd0;
  assign irq_o    = irq_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      evt_q  <= '0;
      pend_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      evt_q  <= evt_i;
      pend_q <= (pend_q & ~pend_clr) | (evt_i & ~evt_q);
      irq_q  <= |pend_q;
    end
`endif
  always_comb begin
    rd_val = '0;
    for (int k = 0; k < NREG; k++)
      if (idx_q == IDX_W'(k)) rd_val = ctl_q[k];
    for (int j = 0; j < NSTAT; j++)
      if (idx_q == IDX_W'(NREG + j)) rd_val = stat_i[32*j +: 32];
`ifdef EPC_SLAVE_IRQ_EN
    if (idx_q == IDX_W'(NREG + NSTAT)) rd_val = pend_q;
`endif
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      be_q     <= '0;
      rnw_q    <= 1'b0;
      wdat_q   <= '0;
      rdy_q    <= 1'b0;
      rdat_q   <= '0;
      ctl_q    <= '0;
      ctl_wr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      be_q    <= be_d;
      rnw_q   <= rnw_d;
      wdat_q  <= wdat_d;
      rdy_q   <= ack;
      if (ack && rnw_q) rdat_q <= rd_val;
      for (int k = 0; k < NREG; k++) begin
        ctl_wr_q[k] <= wr_go && idx_q == IDX_W'(k);
        if (wr_go && idx_q == IDX_W'(k)) ctl_q[k] <= (ctl_q[k] & ~mask) | (wdat_q & mask);
      end
    end
endmodule
